// File: rtl/axi_lite_arbiter_2to1_if.sv
// rtl/axi_lite_arbiter_2to1_if.sv - AXI-Lite channel bundle used on both sides of the 2:1 arbiter
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// rtl/axi_lite_arbiter_2to1.sv - whole-transaction 2:1 AXI-Lite arbiter with grant status and per-master counters
module axi_lite_arbiter_2to1 #(
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             aclk,
    input  logic             areset_n,
    axi_lite_if.slave        s0_axi,
    axi_lite_if.slave        s1_axi,
    axi_lite_if.master       m_axi,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] m0_cnt,
    output logic [CNT_W-1:0] m1_cnt
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] m0_cnt_q, m0_cnt_d, m1_cnt_q, m1_cnt_d;
    logic             req0, req1, sel, done;
    logic             st_ar, st_r, st_aw, st_w, st_b;
    logic             o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready;

    assign req0 = s0_axi.arvalid | s0_axi.awvalid;
    assign req1 = s1_axi.arvalid | s1_axi.awvalid;

    assign st_ar = (state_q == RD_ADDR);
    assign st_r  = (state_q == RD_DATA);
    assign st_aw = (state_q == WR_ADDR);
    assign st_w  = (state_q == WR_DATA);
    assign st_b  = (state_q == WR_RESP);

    assign o_arvalid = owner_q ? s1_axi.arvalid : s0_axi.arvalid;
    assign o_awvalid = owner_q ? s1_axi.awvalid : s0_axi.awvalid;
    assign o_wvalid  = owner_q ? s1_axi.wvalid  : s0_axi.wvalid;
    assign o_rready  = owner_q ? s1_axi.rready  : s0_axi.rready;
    assign o_bready  = owner_q ? s1_axi.bready  : s0_axi.bready;

    // Payloads always follow the owner; only the handshake signals are state-gated.
    assign m_axi.araddr  = owner_q ? s1_axi.araddr : s0_axi.araddr;
    assign m_axi.awaddr  = owner_q ? s1_axi.awaddr : s0_axi.awaddr;
    assign m_axi.wdata   = owner_q ? s1_axi.wdata  : s0_axi.wdata;
    assign m_axi.wstrb   = owner_q ? s1_axi.wstrb  : s0_axi.wstrb;
    assign m_axi.arvalid = st_ar & o_arvalid;
    assign m_axi.awvalid = st_aw & o_awvalid;
    assign m_axi.wvalid  = st_w  & o_wvalid;
    assign m_axi.rready  = st_r  & o_rready;
    assign m_axi.bready  = st_b  & o_bready;

    assign s0_axi.arready = st_ar & ~owner_q & m_axi.arready;
    assign s0_axi.awready = st_aw & ~owner_q & m_axi.awready;
    assign s0_axi.wready  = st_w  & ~owner_q & m_axi.wready;
    assign s0_axi.rvalid  = st_r  & ~owner_q & m_axi.rvalid;
    assign s0_axi.bvalid  = st_b  & ~owner_q & m_axi.bvalid;
    assign s0_axi.rdata   = m_axi.rdata;
    assign s0_axi.rresp   = m_axi.rresp;
    assign s0_axi.bresp   = m_axi.bresp;

    assign s1_axi.arready = st_ar & owner_q & m_axi.arready;
    assign s1_axi.awready = st_aw & owner_q & m_axi.awready;
    assign s1_axi.wready  = st_w  & owner_q & m_axi.wready;
    assign s1_axi.rvalid  = st_r  & owner_q & m_axi.rvalid;
    assign s1_axi.bvalid  = st_b  & owner_q & m_axi.bvalid;
    assign s1_axi.rdata   = m_axi.rdata;
    assign s1_axi.rresp   = m_axi.rresp;
    assign s1_axi.bresp   = m_axi.bresp;

    assign done = (st_r & m_axi.rvalid & m_axi.rready) | (st_b & m_axi.bvalid & m_axi.bready);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        m0_cnt_d = m0_cnt_q;
        m1_cnt_d = m1_cnt_q;
        sel      = 1'b0;
        // rr_q names the master that wins a tie in round-robin mode
        if (ARB_MODE == 1) begin
            sel = ~req0;
        end else if (req0 & req1) begin
            sel = rr_q;
        end else begin
            sel = req1;
        end
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d = sel;
                    state_d = (sel ? s1_axi.arvalid : s0_axi.arvalid) ? RD_ADDR : WR_ADDR;
                end
            end
            RD_ADDR: if (m_axi.arvalid & m_axi.arready) state_d = RD_DATA;
            RD_DATA: if (done) state_d = IDLE;
            WR_ADDR: if (m_axi.awvalid & m_axi.awready) state_d = WR_DATA;
            WR_DATA: if (m_axi.wvalid & m_axi.wready) state_d = WR_RESP;
            WR_RESP: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done) begin
            rr_d = ~owner_q;
            if (!owner_q && (m0_cnt_q != {CNT_W{1'b1}})) m0_cnt_d = m0_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (owner_q && (m1_cnt_q != {CNT_W{1'b1}}))  m1_cnt_d = m1_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            m0_cnt_q <= '0;
            m1_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            m0_cnt_q <= m0_cnt_d;
            m1_cnt_q <= m1_cnt_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign grant  = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign m0_cnt = m0_cnt_q;
    assign m1_cnt = m1_cnt_q;
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb/tb_axi_lite_arbiter_2to1.sv - randomized self-checking bench for axi_lite_arbiter_2to1
`timescale 1ns/1ps
module tb_axi_lite_arbiter_2to1;
    localparam int TMO = 300;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    axi_lite_if s_if [4] ();
    axi_lite_if m_if [2] ();

    logic [1:0]  grant_w [2];
    logic        busy_w [2];
    logic [15:0] a_cnt0, a_cnt1;
    logic [3:0]  b_cnt0, b_cnt1;

    // index i = 2*dut + master; dut 0 is round-robin, dut 1 is fixed priority with 4-bit counters
    axi_lite_arbiter_2to1 #(.ARB_MODE(0), .CNT_W(16)) u_rr (
        .aclk(aclk), .areset_n(areset_n), .s0_axi(s_if[0]), .s1_axi(s_if[1]), .m_axi(m_if[0]),
        .grant(grant_w[0]), .busy(busy_w[0]), .m0_cnt(a_cnt0), .m1_cnt(a_cnt1));
    axi_lite_arbiter_2to1 #(.ARB_MODE(1), .CNT_W(4)) u_fp (
        .aclk(aclk), .areset_n(areset_n), .s0_axi(s_if[2]), .s1_axi(s_if[3]), .m_axi(m_if[1]),
        .grant(grant_w[1]), .busy(busy_w[1]), .m0_cnt(b_cnt0), .m1_cnt(b_cnt1));

    logic [31:0] mst_araddr [4], mst_awaddr [4], mst_wdata [4];
    logic [3:0]  mst_wstrb [4];
    logic        mst_arvalid [4], mst_awvalid [4], mst_wvalid [4], mst_rready [4], mst_bready [4];
    wire         arready_w [4], awready_w [4], wready_w [4], rvalid_w [4], bvalid_w [4];
    wire  [31:0] rdata_w [4];
    wire  [1:0]  rresp_w [4], bresp_w [4];

    for (genvar g = 0; g < 4; g++) begin : g_mst
        assign s_if[g].araddr  = mst_araddr[g];
        assign s_if[g].arvalid = mst_arvalid[g];
        assign s_if[g].rready  = mst_rready[g];
        assign s_if[g].awaddr  = mst_awaddr[g];
        assign s_if[g].awvalid = mst_awvalid[g];
        assign s_if[g].wdata   = mst_wdata[g];
        assign s_if[g].wstrb   = mst_wstrb[g];
        assign s_if[g].wvalid  = mst_wvalid[g];
        assign s_if[g].bready  = mst_bready[g];
        assign arready_w[g] = s_if[g].arready;
        assign awready_w[g] = s_if[g].awready;
        assign wready_w[g]  = s_if[g].wready;
        assign rvalid_w[g]  = s_if[g].rvalid;
        assign bvalid_w[g]  = s_if[g].bvalid;
        assign rdata_w[g]   = s_if[g].rdata;
        assign rresp_w[g]   = s_if[g].rresp;
        assign bresp_w[g]   = s_if[g].bresp;
    end

    logic slv_hold = 1'b0;
    wire  m_arvalid_w [2], m_awvalid_w [2], m_wvalid_w [2], m_rready_w [2], m_bready_w [2];

    for (genvar d = 0; d < 2; d++) begin : g_slv
        logic [31:0] mem [256];
        logic [7:0]  aw_idx = 8'h00;
        logic        arr = 1'b0, awr = 1'b0, wr = 1'b0, rv = 1'b0, bv = 1'b0;
        logic [31:0] rd = 32'h0;
        assign m_if[d].arready = arr;
        assign m_if[d].rvalid  = rv;
        assign m_if[d].rdata   = rd;
        assign m_if[d].rresp   = 2'b00;
        assign m_if[d].awready = awr;
        assign m_if[d].wready  = wr & ~slv_hold;
        assign m_if[d].bvalid  = bv;
        assign m_if[d].bresp   = 2'b00;
        assign m_arvalid_w[d] = m_if[d].arvalid;
        assign m_awvalid_w[d] = m_if[d].awvalid;
        assign m_wvalid_w[d]  = m_if[d].wvalid;
        assign m_rready_w[d]  = m_if[d].rready;
        assign m_bready_w[d]  = m_if[d].bready;
        initial for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        always @(posedge aclk) begin
            arr <= ($urandom_range(0, 3) != 0);
            awr <= ($urandom_range(0, 3) != 0);
            wr  <= ($urandom_range(0, 3) != 0);
            if (!areset_n) begin
                rv <= 1'b0;
                bv <= 1'b0;
            end else begin
                if (m_if[d].arvalid && arr) begin
                    rv <= 1'b1;
                    rd <= mem[m_if[d].araddr[7:0]];
                end else if (rv && m_if[d].rready) begin
                    rv <= 1'b0;
                end
                if (m_if[d].awvalid && awr) aw_idx <= m_if[d].awaddr[7:0];
                if (m_if[d].wvalid && wr && !slv_hold) begin
                    for (int b = 0; b < 4; b++)
                        if (m_if[d].wstrb[b]) mem[aw_idx][8*b +: 8] <= m_if[d].wdata[8*b +: 8];
                    bv <= 1'b1;
                end else if (bv && m_if[d].bready) begin
                    bv <= 1'b0;
                end
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    int iso_bad = 0, wr_early = 0;
    int aw_hs [4] = '{0, 0, 0, 0};
    int exp_cnt [4] = '{0, 0, 0, 0};
    logic [31:0] model [2][256];
    logic [1:0]  prev_g [2] = '{2'b00, 2'b00};
    int gq0 [$];
    int gq1 [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            if ($countones(grant_w[d]) > 1 || busy_w[d] != (grant_w[d] != 2'b00)) iso_bad++;
            if (grant_w[d] == 2'b00 && (m_arvalid_w[d] | m_awvalid_w[d] | m_wvalid_w[d] |
                                        m_rready_w[d] | m_bready_w[d])) iso_bad++;
            for (int m = 0; m < 2; m++)
                if (!grant_w[d][m] && (arready_w[2*d+m] | awready_w[2*d+m] | wready_w[2*d+m] |
                                       rvalid_w[2*d+m] | bvalid_w[2*d+m])) iso_bad++;
            if (grant_w[d] != 2'b00 && prev_g[d] == 2'b00) begin
                if (d == 0) gq0.push_back(int'(grant_w[d]));
                else        gq1.push_back(int'(grant_w[d]));
            end
            prev_g[d] = grant_w[d];
        end
        for (int i = 0; i < 4; i++) if (mst_awvalid[i] && awready_w[i]) aw_hs[i]++;
    end

    task automatic do_rd(input int i, input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int t;
        mst_araddr[i] = {24'h0, a};
        mst_arvalid[i] = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!arready_w[i] && t < TMO) begin @(negedge aclk); t++; end
        chk("ar_handshake", arready_w[i], 1);
        @(posedge aclk); #1 mst_arvalid[i] = 1'b0;
        t = 0; d = '0; r = '1;
        forever begin
            @(negedge aclk);
            mst_rready[i] = (t > 4) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rvalid_w[i] && mst_rready[i]) begin d = rdata_w[i]; r = rresp_w[i]; break; end
            if (++t > TMO) break;
        end
        chk("r_handshake", rvalid_w[i], 1);
        @(posedge aclk); #1 mst_rready[i] = 1'b0;
    endtask

    task automatic do_wr(input int i, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        mst_awaddr[i] = {24'h0, a}; mst_wdata[i] = d; mst_wstrb[i] = s;
        mst_awvalid[i] = 1'b1; mst_wvalid[i] = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!awready_w[i] && t < TMO) begin
            if (wready_w[i]) wr_early++;
            @(negedge aclk); t++;
        end
        chk("aw_handshake", awready_w[i], 1);
        @(posedge aclk); #1 mst_awvalid[i] = 1'b0;
        t = 0;
        @(negedge aclk);
        while (!wready_w[i] && t < TMO) begin @(negedge aclk); t++; end
        chk("w_handshake", wready_w[i], 1);
        @(posedge aclk); #1 mst_wvalid[i] = 1'b0;
        t = 0;
        forever begin
            @(negedge aclk);
            mst_bready[i] = (t > 4) ? 1'b1 : 1'($urandom_range(0, 1));
            if (bvalid_w[i] && mst_bready[i]) break;
            if (++t > TMO) break;
        end
        chk("b_handshake", bvalid_w[i], 1);
        chk("bresp", bresp_w[i], 0);
        @(posedge aclk); #1 mst_bready[i] = 1'b0;
    endtask

    task automatic rd_chk(input int i, input logic [7:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        do_rd(i, a, d, r);
        chk("rdata", d, model[i/2][a]);
        chk("rresp", r, 0);
        exp_cnt[i]++;
    endtask

    task automatic wr_upd(input int i, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        do_wr(i, a, d, s);
        for (int b = 0; b < 4; b++) if (s[b]) model[i/2][a][8*b +: 8] = d[8*b +: 8];
        exp_cnt[i]++;
    endtask

    function automatic int sat(input int n, input int w);
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    task automatic cnt_chk(input string tag);
        chk({tag, "_rr_m0_cnt"}, a_cnt0, sat(exp_cnt[0], 16));
        chk({tag, "_rr_m1_cnt"}, a_cnt1, sat(exp_cnt[1], 16));
        chk({tag, "_fp_m0_cnt"}, b_cnt0, sat(exp_cnt[2], 4));
        chk({tag, "_fp_m1_cnt"}, b_cnt1, sat(exp_cnt[3], 4));
    endtask

    task automatic rand_traffic(input int i, input int n);
        logic [7:0] a;
        int gap;
        repeat (n) begin
            a = {i[0], 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 1) == 1) rd_chk(i, a);
            else wr_upd(i, a, $urandom, 4'($urandom_range(1, 15)));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin repeat (gap) @(posedge aclk); #1; end
        end
    endtask

    task automatic clear_masters();
        for (int i = 0; i < 4; i++) begin
            mst_araddr[i] = '0; mst_awaddr[i] = '0; mst_wdata[i] = '0; mst_wstrb[i] = '0;
            mst_arvalid[i] = 1'b0; mst_awvalid[i] = 1'b0; mst_wvalid[i] = 1'b0;
            mst_rready[i] = 1'b0; mst_bready[i] = 1'b0;
            exp_cnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b0;
        clear_masters();
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int base;
        int t;
        for (int d = 0; d < 2; d++) for (int k = 0; k < 256; k++) model[d][k] = 32'h0;
        clear_masters();
        repeat (3) @(negedge aclk);
        chk("rst_grant", {grant_w[0], grant_w[1]}, 0);
        chk("rst_busy", {busy_w[0], busy_w[1]}, 0);
        cnt_chk("rst");
        chk("rst_m_valids", {m_arvalid_w[0], m_awvalid_w[0], m_wvalid_w[0], m_rready_w[0], m_bready_w[0]}, 0);
        areset_n = 1'b1;
        @(posedge aclk); #1;

        wr_upd(0, 8'h05, 32'hDEADBEEF, 4'hF);
        rd_chk(0, 8'h05);
        chk("t1_m0_cnt", a_cnt0, 2);

        wr_upd(1, 8'h85, 32'h1234_5678, 4'hF);
        wr_upd(0, 8'h06, 32'hCAFE_F00D, 4'b0101);
        do_reset();
        gq0.delete();
        fork
            rd_chk(0, 8'h06);
            rd_chk(1, 8'h85);
        join
        chk("t2_grants", gq0.size(), 2);
        chk("t2_first", (gq0.size() > 0) ? gq0[0] : 0, 1);
        chk("t2_second", (gq0.size() > 1) ? gq0[1] : 0, 2);

        base = aw_hs[1];
        mst_awaddr[1] = 32'h9A; mst_wdata[1] = 32'hA5A5_5A5A; mst_wstrb[1] = 4'hF;
        mst_awvalid[1] = 1'b1; mst_wvalid[1] = 1'b1;
        rd_chk(1, 8'h85);
        chk("t4_aw_waits", aw_hs[1] - base, 0);
        wr_upd(1, 8'h9A, 32'hA5A5_5A5A, 4'hF);
        rd_chk(1, 8'h9A);
        cnt_chk("t4");

        fork
            rand_traffic(0, 12);
            rand_traffic(1, 12);
        join
        cnt_chk("rand");

        gq1.delete();
        fork
            begin rd_chk(2, 8'h05); rd_chk(2, 8'h06); rd_chk(2, 8'h07); end
            rd_chk(3, 8'h85);
        join
        chk("t3_grants", gq1.size(), 4);
        for (int k = 0; k < 3; k++) chk("t3_m0_first", (gq1.size() > k) ? gq1[k] : 0, 1);
        chk("t3_m1_last", (gq1.size() > 3) ? gq1[3] : 0, 2);

        rand_traffic(2, 14);
        chk("t6_sat", b_cnt0, 4'hF);
        wr_upd(2, 8'h11, 32'h0BAD_CAFE, 4'hF);
        rd_chk(2, 8'h11);
        cnt_chk("t6");

        slv_hold = 1'b1;
        mst_awaddr[1] = 32'h90; mst_wdata[1] = 32'h1111_2222; mst_wstrb[1] = 4'hF;
        mst_awvalid[1] = 1'b1; mst_wvalid[1] = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!awready_w[1] && t < TMO) begin @(negedge aclk); t++; end
        chk("t5_aw_handshake", awready_w[1], 1);
        @(posedge aclk); #1 mst_awvalid[1] = 1'b0;
        @(negedge aclk);
        chk("t5_in_wr_data", m_wvalid_w[0], 1);
        areset_n = 1'b0;
        #1;
        chk("t5_rst_handshakes", {m_arvalid_w[0], m_awvalid_w[0], m_wvalid_w[0], m_rready_w[0], m_bready_w[0],
                                  arready_w[1], awready_w[1], wready_w[1], rvalid_w[1], bvalid_w[1]}, 0);
        chk("t5_rst_grant", grant_w[0], 0);
        chk("t5_rst_busy", busy_w[0], 0);
        slv_hold = 1'b0;
        clear_masters();
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk); #1;
        rd_chk(1, 8'h9A);
        rd_chk(1, 8'h90);
        cnt_chk("t5");

        chk("isolation", iso_bad, 0);
        chk("wready_early", wr_early, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
